e_mdu: RTL and testbench
========================

# e_mdu

Multi-cycle multiply/divide unit controller for the EX stage of the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo requests from the EX stage and sequences the fixed-latency operation with an internal countdown. It owns the HI/LO architectural registers and exposes a `busy` flag, which the hazard unit uses to stall later md-class instructions. Reads for mfhi/mflo are served combinationally from HI/LO.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  request valid this cycle.
- `op`  in  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- `in1`  in  32  rs operand (dividend / multiplicand / mthi-mtlo data).
- `in2`  in  32  rt operand (divisor / multiplier).
- `rd_sel`  in  1  0 selects LO, 1 selects HI for `rd_data`.
- `busy`  out  1  operation in flight.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.
- `rd_data`  out  32  `rd_sel ? HI : LO`, combinational.

## Operation
- States: IDLE, RUN. A countdown `cnt` is sized for `max(MULT_CYCLES, DIV_CYCLES)`. Pending-result registers are `tmp_hi` and `tmp_lo`.
- **IDLE, `start` with op 1–4:** compute the result from `in1`/`in2` at this edge into `tmp_hi`/`tmp_lo`, load `cnt` with N (MULT_CYCLES or DIV_CYCLES), and go to RUN.
  - Operands are not required to stay stable afterwards.
- **IDLE, `start` with op 5 (mthi) or 6 (mtlo):** write `in1` to HI or LO at this edge. State stays IDLE and `busy` never asserts.
- **IDLE, `start` with op 0 or 7:** ignored.
- **RUN:** decrement `cnt` each edge. On the edge where `cnt` is 1:
  - HI ← `tmp_hi`, LO ← `tmp_lo`;
  - go to IDLE.
- **RUN, `start` asserted (any op):** ignored, including mthi/mtlo. Upstream must stall on `busy`; a bench asserts no request is lost only when the stall protocol is obeyed.
- `busy` is 1 exactly when state is RUN.
- **Arithmetic:**
  - mult: signed 32×32→64, HI = [63:32], LO = [31:0].
  - multu: same, unsigned.
  - div: signed; LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - divu: unsigned quotient to LO, remainder to HI.
- **Boundary cases:**
  - Divide by zero (div or divu, `in2` = 0): full DIV_CYCLES busy period runs, but HI/LO remain unchanged at completion.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. Must not trap and must not produce X.
- **Reset (async, any time, including mid-RUN):** state → IDLE, `cnt` = 0, `busy` = 0, HI = LO = `tmp_hi` = `tmp_lo` = 0. Any in-flight result is discarded.

## Timing
- `start` sampled at edge E0. `busy` = 1 in the cycles after E0 through E0+N, i.e. exactly N cycles.
- HI/LO take the new value at edge E0+N and are visible in the cycle after it. `busy` falls on that same edge.
- A new request may be issued in the first cycle `busy` is 0. Back-to-back operations therefore issue every N+1 cycles.
- mthi/mtlo: HI/LO visible the cycle after the sampling edge, with zero busy cycles.
- `rd_data` is combinational from HI/LO. It returns the old value while `busy` = 1; the hazard unit stalls mfhi/mflo on `busy`.
- Reset deassertion: first request may be sampled at the first rising edge after `reset` falls.

## Test plan
- **mult:** `start`, op 1, `in1` = 0xFFFFFFFD (−3), `in2` = 5 → `busy` high for exactly 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- **multu, then div:**
  - multu 0xFFFFFFFF × 2 → HI = 1, LO = 0xFFFFFFFE after 5 cycles.
  - Then immediately div, `in1` = 0xFFFFFFF9 (−7), `in2` = 2 → `busy` for 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- **divu with intervening requests:** divu 7/2 → LO = 3, HI = 1. While `busy`, issue mthi 0x1234 and mult requests → both ignored; final HI = 1, LO = 3, `busy` duration unchanged.
- **Divide by zero:** preload HI = 0xAAAA0000 via mthi and LO = 0x5555 via mtlo (each 0 busy cycles). Then div `in2` = 0 → `busy` 10 cycles, HI/LO unchanged. Then div 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Reset mid-run:** start mult 3×4, assert `reset` asynchronously in busy cycle 2 (between edges) → `busy`, HI, LO = 0 immediately. After release, no late write of 12 occurs; a new divu 9/4 completes normally with LO = 2, HI = 1.
- **rd_data mux:** with HI = 1, LO = 3, toggle `rd_sel` → `rd_data` follows 3/1 in the same cycle, including while `busy` = 1.

Source files
------------

// File: rtl/e_mdu_if.sv
// EX-stage <-> multiply/divide unit bundle: request fields, busy flag and HI/LO read-back.
// The EX stage holds the master modport and the unit holds the slave modport.
interface e_mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        rd_sel;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] rd_data;

  modport master (
    output start, op, in1, in2, rd_sel,
    input  busy, HI, LO, rd_data
  );

  modport slave (
    input  start, op, in1, in2, rd_sel,
    output busy, HI, LO, rd_data
  );
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide controller that owns HI/LO.
// The result is computed when the request is accepted and is committed after a fixed countdown.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   tmpHi_q, tmpHi_d, tmpLo_q, tmpLo_d;

  logic [63:0] prodS, prodU;
  logic        dvdNeg, dvsNeg, divByZero;
  logic [31:0] dvdMag, dvsMag, dvsMagSafe, dvsUSafe;
  logic [31:0] quoMag, remMag, quoS, remS, quoU, remU;

  // Sign-extending to 64 bits makes a plain modulo-2^64 product equal the signed product.
  assign prodS = {{32{bus.in1[31]}}, bus.in1} * {{32{bus.in2[31]}}, bus.in2};
  assign prodU = {32'd0, bus.in1} * {32'd0, bus.in2};

  // Signed divide runs on magnitudes, so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
  assign divByZero  = (bus.in2 == 32'd0);
  assign dvdNeg     = bus.in1[31];
  assign dvsNeg     = bus.in2[31];
  assign dvdMag     = dvdNeg ? (32'd0 - bus.in1) : bus.in1;
  assign dvsMag     = dvsNeg ? (32'd0 - bus.in2) : bus.in2;
  assign dvsMagSafe = divByZero ? 32'd1 : dvsMag;
  assign dvsUSafe   = divByZero ? 32'd1 : bus.in2;
  assign quoMag     = dvdMag / dvsMagSafe;
  assign remMag     = dvdMag % dvsMagSafe;
  assign quoS       = (dvdNeg ^ dvsNeg) ? (32'd0 - quoMag) : quoMag;
  assign remS       = dvdNeg ? (32'd0 - remMag) : remMag;
  assign quoU       = bus.in1 / dvsUSafe;
  assign remU       = bus.in1 % dvsUSafe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      tmpHi_q <= 32'd0;
      tmpLo_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      tmpHi_q <= tmpHi_d;
      tmpLo_q <= tmpLo_d;
    end
  end

  // A divide by zero stages the current HI/LO, so the commit at the end of the countdown is a no-op.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    tmpHi_d = tmpHi_q;
    tmpLo_d = tmpLo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'd1: begin
              {tmpHi_d, tmpLo_d} = prodS;
              cnt_d   = MULT_N;
              state_d = RUN;
            end
            3'd2: begin
              {tmpHi_d, tmpLo_d} = prodU;
              cnt_d   = MULT_N;
              state_d = RUN;
            end
            3'd3: begin
              tmpHi_d = divByZero ? hi_q : remS;
              tmpLo_d = divByZero ? lo_q : quoS;
              cnt_d   = DIV_N;
              state_d = RUN;
            end
            3'd4: begin
              tmpHi_d = divByZero ? hi_q : remU;
              tmpLo_d = divByZero ? lo_q : quoU;
              cnt_d   = DIV_N;
              state_d = RUN;
            end
            3'd5:    hi_d = bus.in1;
            3'd6:    lo_d = bus.in1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == ONE) begin
          hi_d    = tmpHi_q;
          lo_d    = tmpLo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    endcase
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;
endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed and random requests checked against a plain-arithmetic HI/LO model.
module tb_e_mdu;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;
  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCount = 0;
  int checkCount = 0;
  logic [31:0] expHi = 32'd0;
  logic [31:0] expLo = 32'd0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Architectural effect of one accepted request, computed with 64-bit integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] nh, output logic [31:0] nl, output int n);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    nh = expHi;
    nl = expLo;
    n  = 0;
    case (op)
      3'd1: begin p = 64'(sa * sb); nh = p[63:32]; nl = p[31:0]; n = MULT_N; end
      3'd2: begin p = 64'(ua * ub); nh = p[63:32]; nl = p[31:0]; n = MULT_N; end
      3'd3: begin
        n = DIV_N;
        if (b != 32'd0) begin
          sq = sa / sb; sr = sa % sb;
          nl = 32'(sq); nh = 32'(sr);
        end
      end
      3'd4: begin
        n = DIV_N;
        if (b != 32'd0) begin
          nl = 32'(ua / ub); nh = 32'(ua % ub);
        end
      end
      3'd5: nh = a;
      3'd6: nl = a;
      default: ;
    endcase
  endfunction

  // Called at a negedge; issues one request, watches the busy window, then checks the commit.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit noise);
    logic [31:0] nh, nl;
    int n;
    logic sel;
    model(op, a, b, nh, nl, n);
    bus.start = 1'b1; bus.op = op; bus.in1 = a; bus.in2 = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd0; bus.in1 = $urandom; bus.in2 = $urandom;
    for (int i = 0; i < n; i++) begin
      checkOutput("busyHigh", 32'(bus.busy), 32'd1);
      sel = 1'($urandom_range(0, 1));
      bus.rd_sel = sel;
      #1;
      checkOutput("rdDataOld", bus.rd_data, sel ? expHi : expLo);
      if (noise) begin
        bus.start = 1'b1;
        bus.op    = (i % 2 == 0) ? 3'd5 : 3'd1;
        bus.in1   = 32'h1234;
        bus.in2   = 32'd3;
      end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.op = 3'd0;
    checkOutput("busyLow", 32'(bus.busy), 32'd0);
    checkOutput("HI", bus.HI, nh);
    checkOutput("LO", bus.LO, nl);
    expHi = nh;
    expLo = nl;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 3'd0; bus.in1 = 32'd0; bus.in2 = 32'd0; bus.rd_sel = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstHI", bus.HI, 32'd0);
    checkOutput("rstLO", bus.LO, 32'd0);
    reset = 1'b0;

    applyStimulus(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
    applyStimulus(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    applyStimulus(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    applyStimulus(3'd4, 32'd7, 32'd2, 1'b1);

    bus.rd_sel = 1'b0; #1; checkOutput("rdSelLo", bus.rd_data, 32'd3);
    bus.rd_sel = 1'b1; #1; checkOutput("rdSelHi", bus.rd_data, 32'd1);
    @(negedge clk);

    applyStimulus(3'd5, 32'hAAAA0000, 32'd0, 1'b0);
    applyStimulus(3'd6, 32'h00005555, 32'd0, 1'b0);
    applyStimulus(3'd3, 32'd1234, 32'd0, 1'b0);
    applyStimulus(3'd4, 32'hDEADBEEF, 32'd0, 1'b0);
    applyStimulus(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    applyStimulus(3'd0, 32'h11111111, 32'd1, 1'b0);
    applyStimulus(3'd7, 32'h22222222, 32'd1, 1'b0);

    // Asynchronous reset between edges in the second busy cycle of a mult.
    bus.start = 1'b1; bus.op = 3'd1; bus.in1 = 32'd3; bus.in2 = 32'd4;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
    checkOutput("midRstHI", bus.HI, 32'd0);
    checkOutput("midRstLO", bus.LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    expHi = 32'd0;
    expLo = 32'd0;
    repeat (MULT_N + 1) begin
      @(negedge clk);
      checkOutput("noLateBusy", 32'(bus.busy), 32'd0);
      checkOutput("noLateLO", bus.LO, 32'd0);
    end
    applyStimulus(3'd4, 32'd9, 32'd4, 1'b0);

    for (int k = 0; k < 30; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      applyStimulus(rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
